firebird7_in_gate1_tessent_mbisr_chain_ctrl: RTL and testbench

FIREBIRD7_IN_GATE1_TESSENT_MBISR_CHAIN_CTRL -- requirements
Module: firebird7_in_gate1_tessent_mbisr_chain_ctrl

---
 rtl/firebird7_in_gate1_tessent_mbisr_chain_ctrl.sv | 176 +++++++++++++++++
 tb/tb_firebird7_in_gate1_tessent_mbisr_chain_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/firebird7_in_gate1_tessent_mbisr_chain_ctrl.sv
// Repair-chain shift controller: loads 32-bit words into, or unloads words from, a gated scan chain.
// Optional CRC-16-CCITT over shifted bits is built when FIREBIRD7_MBISR_CHAIN_CRC_EN is defined.
module firebird7_in_gate1_tessent_mbisr_chain_ctrl #(
    parameter int LEN_W = 16
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             START,
    input  logic             MODE,
    input  logic [LEN_W-1:0] CHAIN_LEN,
    input  logic [31:0]      WDATA,
    input  logic             WVALID,
    output logic             WREADY,
    output logic [31:0]      RDATA,
    output logic             RVALID,
    input  logic             RREADY,
    output logic             SE,
    output logic             SI,
    input  logic             SO_IN,
    output logic             CKEN,
    output logic             BUSY,
    output logic             DONE,
    output logic [15:0]      CRC
);

    typedef enum logic [2:0] {ST_IDLE, ST_CAPT, ST_SHIFT, ST_FLUSH, ST_DONE} state_t;

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         bidx_q, bidx_d;
    logic [31:0]        wbuf_q, wbuf_d;
    logic               wfull_q, wfull_d;
    logic [31:0]        sh_q, sh_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;
    logic               word_end;

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q  <= ST_IDLE;
            mode_q   <= 1'b0;
            cnt_q    <= '0;
            bidx_q   <= '0;
            wbuf_q   <= '0;
            wfull_q  <= 1'b0;
            sh_q     <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            bidx_q   <= bidx_d;
            wbuf_q   <= wbuf_d;
            wfull_q  <= wfull_d;
            sh_q     <= sh_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // A bit closes the current word when it is bit 31 or the last bit of the chain.
    assign word_end = (bidx_q == 5'd31) || (cnt_q == LEN_W'(1));

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        bidx_d   = bidx_q;
        wbuf_d   = wbuf_q;
        wfull_d  = wfull_q;
        sh_d     = sh_q;
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
        CKEN     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    mode_d  = MODE;
                    cnt_d   = CHAIN_LEN;
                    bidx_d  = '0;
                    wfull_d = 1'b0;
                    sh_d    = '0;
                    if (CHAIN_LEN == '0) state_d = ST_DONE;
                    else if (MODE)       state_d = ST_CAPT;
                    else                 state_d = ST_SHIFT;
                end
            end
            ST_CAPT: begin
                CKEN    = 1'b1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (!mode_q) begin
                    if (!wfull_q) begin
                        if (WVALID) begin
                            wbuf_d  = WDATA;
                            wfull_d = 1'b1;
                        end
                    end else begin
                        CKEN   = 1'b1;
                        wbuf_d = wbuf_q >> 1;
                        bidx_d = bidx_q + 5'd1;
                        cnt_d  = cnt_q - LEN_W'(1);
                        if (word_end) begin
                            wfull_d = 1'b0;
                            bidx_d  = '0;
                        end
                        if (cnt_q == LEN_W'(1)) state_d = ST_DONE;
                    end
                end else begin
                    if (RREADY) rvalid_d = 1'b0;
                    // Hold the chain only if the word now closing has nowhere to go.
                    if (!(word_end && rvalid_q && !RREADY)) begin
                        CKEN  = 1'b1;
                        cnt_d = cnt_q - LEN_W'(1);
                        if (word_end) begin
                            rdata_d  = sh_q | ({31'd0, SO_IN} << bidx_q);
                            rvalid_d = 1'b1;
                            sh_d     = '0;
                            bidx_d   = '0;
                        end else begin
                            sh_d   = sh_q | ({31'd0, SO_IN} << bidx_q);
                            bidx_d = bidx_q + 5'd1;
                        end
                        if (cnt_q == LEN_W'(1)) state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (!rvalid_q || RREADY) begin
                    rvalid_d = 1'b0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign SE     = (state_q == ST_SHIFT);
    assign SI     = (state_q == ST_SHIFT) && !mode_q && wfull_q && wbuf_q[0];
    assign WREADY = (state_q == ST_SHIFT) && !mode_q && !wfull_q;
    assign BUSY   = (state_q != ST_IDLE);
    assign DONE   = (state_q == ST_DONE);
    assign RDATA  = rdata_q;
    assign RVALID = rvalid_q;

`ifdef FIREBIRD7_MBISR_CHAIN_CRC_EN
    logic [15:0] crc_q;
    logic        crc_bit;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    assign crc_bit = mode_q ? SO_IN : wbuf_q[0];

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB)
            crc_q <= '0;
        else if (state_q == ST_IDLE && START)
            crc_q <= 16'hFFFF;
        else if (state_q == ST_SHIFT && CKEN)
            crc_q <= crc_step(crc_q, crc_bit);
    end

    assign CRC = crc_q;
`else
    assign CRC = '0;
`endif

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_mbisr_chain_ctrl.sv
// Directed bench for the repair-chain controller, with a behavioural scan chain on SI/SO_IN.
module tb_firebird7_in_gate1_tessent_mbisr_chain_ctrl;

    logic        CLK = 1'b0;
    logic        RSTB, START, MODE, WVALID, RREADY;
    logic [15:0] CHAIN_LEN;
    logic [31:0] WDATA;
    logic        WREADY, RVALID, SE, SI, SO_IN, CKEN, BUSY, DONE;
    logic [31:0] RDATA;
    logic [15:0] CRC;

    int n_tests = 0;
    int n_fail  = 0;

    firebird7_in_gate1_tessent_mbisr_chain_ctrl #(.LEN_W(16)) dut (
        .CLK(CLK), .RSTB(RSTB), .START(START), .MODE(MODE), .CHAIN_LEN(CHAIN_LEN),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
        .SE(SE), .SI(SI), .SO_IN(SO_IN), .CKEN(CKEN),
        .BUSY(BUSY), .DONE(DONE), .CRC(CRC)
    );

    always #5 CLK = ~CLK;

    // Behavioural repair chain: capture D when SE=0, shift toward bit 0 when SE=1.
    logic [127:0] chain = '0;
    logic [127:0] chain_d;
    assign SO_IN = chain[0];
    always @(posedge CLK) begin
        if (CKEN) chain <= SE ? {SI, chain[127:1]} : chain_d;
    end

    // Activity monitor, sampled on the falling edge.
    int   cyc = 0, shifts = 0, capts = 0, stalls = 0, rvcyc = 0, dones = 0, nwords = 0;
    int   se_low = 0, viol = 0, op_shift = 0, op_len = 0, last_shift_cyc = 0, done_cyc = 0;
    logic        si_hist [0:4095];
    logic [31:0] word_hist [0:63];
    always @(negedge CLK) begin
        if (RSTB) begin
            if (START && !BUSY) begin
                op_len   = int'(CHAIN_LEN);
                op_shift = 0;
            end
            if (CKEN && SE) begin
                if (RVALID && !RREADY && ((op_shift % 32) == 31 || op_shift == op_len - 1)) viol++;
                si_hist[shifts] = SI;
                shifts++;
                op_shift++;
                last_shift_cyc = cyc;
            end
            if (CKEN && !SE) capts++;
            if (SE && !CKEN) stalls++;
            if (BUSY && !SE && !DONE) se_low++;
            if (RVALID) rvcyc++;
            if (RVALID && RREADY) begin
                word_hist[nwords] = RDATA;
                nwords++;
            end
            if (DONE) begin
                dones++;
                done_cyc = cyc;
            end
        end
        cyc++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic start_op(input logic m, input logic [15:0] len);
        START = 1'b1; MODE = m; CHAIN_LEN = len;
        tick();
        START = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i;
        for (i = 0; i < 2000 && !DONE; i++) tick();
        if (!DONE) chk({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    function automatic logic [15:0] crc_ref(input logic [63:0] bits, input int n);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            logic fb;
            fb = c[15] ^ bits[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    function automatic logic [63:0] si_vec(input int base, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v[i] = si_hist[base + i];
        return v;
    endfunction

    int b_sh, b_cp, b_st, b_rv, b_dn, b_wd, b_se, b_vi;
    task automatic snap;
        b_sh = shifts; b_cp = capts; b_st = stalls; b_rv = rvcyc;
        b_dn = dones;  b_wd = nwords; b_se = se_low; b_vi = viol;
    endtask

    logic [15:0] crc_exp;

    initial begin
        RSTB = 1'b0; START = 1'b0; MODE = 1'b0; CHAIN_LEN = '0;
        WDATA = '0; WVALID = 1'b0; RREADY = 1'b0; chain_d = '0;
        repeat (3) tick();
        chk("rst_ctl", {57'd0, SE, SI, CKEN, WREADY, RVALID, BUSY, DONE}, 64'd0);
        chk("rst_rdata", {32'd0, RDATA}, 64'd0);
        chk("rst_crc", {48'd0, CRC}, 64'd0);
        RSTB = 1'b1;
        tick();

        // LOAD 26 bits of alternating data.
        snap();
        WDATA = 32'h02AAAAAA; WVALID = 1'b1;
        start_op(1'b0, 16'd26);
        wait_done("ld26");
        tick();
        WVALID = 1'b0;
        chk("ld26_shifts", shifts - b_sh, 26);
        chk("ld26_si", si_vec(b_sh, 26), 64'h2AAAAAA);
        chk("ld26_done_lat", done_cyc - last_shift_cyc, 1);
        chk("ld26_dones", dones - b_dn, 1);
        chk("ld26_idle", {62'd0, BUSY, DONE}, 64'd0);

        // UNLOAD 26 bits with RREADY high.
        snap();
        chain_d = 128'h3FF0001; RREADY = 1'b1;
        start_op(1'b1, 16'd26);
        wait_done("ul26");
        tick();
        chk("ul26_capt", capts - b_cp, 1);
        chk("ul26_shifts", shifts - b_sh, 26);
        chk("ul26_words", nwords - b_wd, 1);
        chk("ul26_word0", {32'd0, word_hist[b_wd]}, 64'h03FF0001);
        chk("ul26_rvcyc", rvcyc - b_rv, 1);

        // UNLOAD 70 bits with RREADY held low long enough to force a stall.
        snap();
        chain_d = 128'h2D_CAFEF00D_13579BDF; RREADY = 1'b0;
        start_op(1'b1, 16'd70);
        for (int i = 0; i < 200 && !RVALID; i++) tick();
        chk("ul70_rvalid_seen", {63'd0, RVALID}, 64'd1);
        START = 1'b1; MODE = 1'b0; CHAIN_LEN = 16'd0;
        tick();
        START = 1'b0;
        repeat (39) tick();
        RREADY = 1'b1;
        wait_done("ul70");
        tick();
        chk("ul70_shifts", shifts - b_sh, 70);
        chk("ul70_words", nwords - b_wd, 3);
        chk("ul70_word0", {32'd0, word_hist[b_wd]}, 64'h13579BDF);
        chk("ul70_word1", {32'd0, word_hist[b_wd + 1]}, 64'hCAFEF00D);
        chk("ul70_word2", {32'd0, word_hist[b_wd + 2]}, 64'h0000002D);
        chk("ul70_stalled", {63'd0, (stalls - b_st) > 0}, 64'd1);
        chk("ul70_no_lost_bit", viol - b_vi, 0);
        chk("ul70_dones", dones - b_dn, 1);

        // LOAD 40 bits with the second word withheld for 5 cycles.
        snap();
        RREADY = 1'b0;
        WDATA = 32'h89ABCDEF; WVALID = 1'b1;
        start_op(1'b0, 16'd40);
        chk("ld40_wready0", {63'd0, WREADY}, 64'd1);
        tick();
        WVALID = 1'b0;
        for (int i = 0; i < 100 && !WREADY; i++) tick();
        chk("ld40_wready1", {63'd0, WREADY}, 64'd1);
        repeat (5) tick();
        WDATA = 32'h000000A5; WVALID = 1'b1;
        wait_done("ld40");
        tick();
        WVALID = 1'b0;
        chk("ld40_shifts", shifts - b_sh, 40);
        chk("ld40_si", si_vec(b_sh, 40), 64'hA5_89ABCDEF);
        chk("ld40_stalls", stalls - b_st, 7);
        chk("ld40_se_held", se_low - b_se, 0);

        // Reset after 10 shifts, then a zero-length operation.
        snap();
        WDATA = 32'hFFFFFFFF; WVALID = 1'b1;
        start_op(1'b0, 16'd100);
        for (int i = 0; i < 100 && (shifts - b_sh) < 10; i++) tick();
        chk("rst_mid_shifts", shifts - b_sh, 10);
        RSTB = 1'b0;
        #1;
        chk("rst_mid_ctl", {57'd0, SE, SI, CKEN, WREADY, RVALID, BUSY, DONE}, 64'd0);
        chk("rst_mid_rdata", {32'd0, RDATA}, 64'd0);
        chk("rst_mid_crc", {48'd0, CRC}, 64'd0);
        WVALID = 1'b0;
        tick();
        tick();
        RSTB = 1'b1;
        tick();
        chk("rst_mid_no_done", dones - b_dn, 0);
        snap();
        start_op(1'b0, 16'd0);
        chk("len0_done", {62'd0, DONE, CKEN}, 64'd2);
`ifdef FIREBIRD7_MBISR_CHAIN_CRC_EN
        chk("len0_crc_seed", {48'd0, CRC}, 64'hFFFF);
`else
        chk("len0_crc_off", {48'd0, CRC}, 64'd0);
`endif
        tick();
        chk("len0_idle", {62'd0, BUSY, DONE}, 64'd0);
        chk("len0_no_shift", (shifts - b_sh) + (capts - b_cp), 0);

        // LOAD 32 zero bits and check the CRC at DONE.
        WDATA = 32'h0; WVALID = 1'b1;
        start_op(1'b0, 16'd32);
        wait_done("crc32");
        WVALID = 1'b0;
`ifdef FIREBIRD7_MBISR_CHAIN_CRC_EN
        crc_exp = crc_ref(64'd0, 32);
`else
        crc_exp = 16'h0000;
`endif
        chk("crc32_done", {48'd0, CRC}, {48'd0, crc_exp});
        tick();
        tick();
        chk("crc32_hold", {48'd0, CRC}, {48'd0, crc_exp});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
